// File: rtl/host_capture_if.sv
// Record stream from host_capture to its consumer: rec_valid/rec_ready handshake
// carrying the head record's cycle stamp and payload.
interface host_capture_if #(
    parameter int CFG_DATA_W = 32
);
    // A record transfers on any rising edge where rec_valid && rec_ready; while
    // rec_valid is high and rec_ready low, rec_count/rec_data hold steady.
    logic                  rec_valid;
    logic                  rec_ready;
    logic [31:0]           rec_count;
    logic [CFG_DATA_W-1:0] rec_data;

    modport master (output rec_valid, output rec_count, output rec_data, input rec_ready);
    modport slave  (input rec_valid, input rec_count, input rec_data, output rec_ready);
endinterface

// File: rtl/host_capture.sv
// Host config-beat capture into a FIFO of {cycle stamp, payload} records.
// Optional macro HOST_CAPTURE_TIMESTAMP_EN enables the cycle counter and stamp storage.
module host_capture #(
    parameter int CFG_DATA_W = 32,
    parameter int DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cap_start,
    input  logic                    cap_stop,
    input  logic                    in_config_valid,
    input  logic [CFG_DATA_W-1:0]   in_config_data,
    host_capture_if.master          rec,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    capturing,
    output logic                    overflow,
    output logic [15:0]             drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {S_IDLE, S_CAPTURE} state_t;

    state_t          state_q;
    logic            overflow_q;
    logic [15:0]     drop_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic [CFG_DATA_W-1:0] data_mem [DEPTH];

    logic push_req;
    logic pop;
    logic full;
    logic push_ok;
    logic drop;
    logic start_ok;

    assign push_req = (state_q == S_CAPTURE) && in_config_valid;
    assign pop      = (level_q != '0) && rec.rec_ready;
    assign full     = (level_q == LW'(DEPTH));
    // A full buffer still takes a beat when the head leaves in the same cycle.
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;
    // cap_stop wins over cap_start when both arrive together.
    assign start_ok = (state_q == S_IDLE) && cap_start && !cap_stop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            overflow_q <= 1'b0;
            drop_q     <= 16'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        state_q    <= S_CAPTURE;
                        overflow_q <= 1'b0;
                        drop_q     <= 16'h0;
                    end
                end
                S_CAPTURE: begin
                    if (cap_stop) begin
                        state_q <= S_IDLE;
                    end
                    if (drop) begin
                        overflow_q <= 1'b1;
                        if (drop_q != 16'hFFFF) begin
                            drop_q <= drop_q + 16'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            data_mem[wr_ptr_q] <= in_config_data;
        end
    end

    assign rec.rec_valid = (level_q != '0);
    assign rec.rec_data  = rec.rec_valid ? data_mem[rd_ptr_q] : '0;

`ifdef HOST_CAPTURE_TIMESTAMP_EN
    logic [31:0] cycle_q;
    logic [31:0] stamp_mem [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_q <= 32'h0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            stamp_mem[wr_ptr_q] <= cycle_q;
        end
    end

    assign rec.rec_count = rec.rec_valid ? stamp_mem[rd_ptr_q] : 32'h0;
`else
    assign rec.rec_count = 32'h0;
`endif

    assign level      = level_q;
    assign capturing  = (state_q == S_CAPTURE);
    assign overflow   = overflow_q;
    assign drop_count = drop_q;
endmodule

// File: tb/tb_host_capture.sv
// Bench for host_capture: queue-based reference model, per-cycle output compare,
// directed scenarios with literal pins, then randomized traffic.
module tb_host_capture;
    localparam int W     = 32;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef HOST_CAPTURE_TIMESTAMP_EN
    localparam bit TS = 1'b1;
`else
    localparam bit TS = 1'b0;
`endif

    logic          clk;
    logic          reset_n;
    logic          cap_start;
    logic          cap_stop;
    logic          in_config_valid;
    logic [W-1:0]  in_config_data;
    logic [LW-1:0] level;
    logic          capturing;
    logic          overflow;
    logic [15:0]   drop_count;

    host_capture_if #(.CFG_DATA_W(W)) rec_if ();

    host_capture #(.CFG_DATA_W(W), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cap_start       (cap_start),
        .cap_stop        (cap_stop),
        .in_config_valid (in_config_valid),
        .in_config_data  (in_config_data),
        .rec             (rec_if),
        .level           (level),
        .capturing       (capturing),
        .overflow        (overflow),
        .drop_count      (drop_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: records are {stamp, data}
    logic [W+31:0] m_q[$];
    logic [W+31:0] popped[$];
    logic [31:0]   m_cnt;
    bit            m_cap;
    bit            m_ovf;
    logic [15:0]   m_drop;

    int checks;
    int errors;
    bit cmp_en;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cnt  = 32'h0;
        m_cap  = 1'b0;
        m_ovf  = 1'b0;
        m_drop = 16'h0;
    endtask

    task automatic model_step();
        if (m_q.size() > 0 && rec_if.rec_ready) begin
            popped.push_back(m_q.pop_front());
        end
        if (m_cap && in_config_valid) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back({m_cnt, in_config_data});
            end else begin
                m_ovf = 1'b1;
                if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            end
        end
        if (cap_stop) begin
            m_cap = 1'b0;
        end else if (cap_start && !m_cap) begin
            m_cap  = 1'b1;
            m_ovf  = 1'b0;
            m_drop = 16'h0;
        end
        m_cnt = m_cnt + 32'd1;
    endtask

    // driver: one clock, model follows the DUT's edge, inputs change after negedge
    task automatic tick();
        @(posedge clk);
        if (reset_n) model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input bit st, input bit sp, input bit v, input logic [W-1:0] d, input bit rdy);
        cap_start       = st;
        cap_stop        = sp;
        in_config_valid = v;
        in_config_data  = d;
        rec_if.rec_ready = rdy;
    endtask

    task automatic idle_inputs(input bit rdy);
        drive(1'b0, 1'b0, 1'b0, '0, rdy);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        idle_inputs(1'b0);
        tick();
        tick();
        reset_n = 1'b1;
        popped.delete();
    endtask

    // scoreboard compare: every cycle, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("rec_valid", 64'(rec_if.rec_valid), 64'(m_q.size() > 0));
                chk("level", 64'(level), 64'(m_q.size()));
                chk("capturing", 64'(capturing), 64'(m_cap));
                chk("overflow", 64'(overflow), 64'(m_ovf));
                chk("drop_count", 64'(drop_count), 64'(m_drop));
                if (m_q.size() > 0) begin
                    chk("rec_data", 64'(rec_if.rec_data), 64'(m_q[0][W-1:0]));
                    chk("rec_count", 64'(rec_if.rec_count), TS ? 64'(m_q[0][W+31:W]) : 64'h0);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        cmp_en = 1'b0;
        reset_n = 1'b0;
        idle_inputs(1'b0);
        model_reset();
        #2;
        // reset values while reset_n is held low
        chk("rst_rec_valid", 64'(rec_if.rec_valid), 64'h0);
        chk("rst_level", 64'(level), 64'h0);
        chk("rst_capturing", 64'(capturing), 64'h0);
        chk("rst_overflow", 64'(overflow), 64'h0);
        chk("rst_drop", 64'(drop_count), 64'h0);
        chk("rst_rec_count", 64'(rec_if.rec_count), 64'h0);
        chk("rst_rec_data", 64'(rec_if.rec_data), 64'h0);
        cmp_en = 1'b1;
        do_reset();

        // in-order stamped capture: cap_start in cycle 5, beats in cycles 7..9
        for (int i = 0; i < 5; i++) begin
            idle_inputs(1'b1);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
        tick();
        idle_inputs(1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, W'(32'hA0 + i), 1'b1);
            tick();
        end
        idle_inputs(1'b1);
        for (int i = 0; i < 5; i++) tick();
        chk("basic_n", 64'(popped.size()), 64'd3);
        for (int i = 0; i < 3 && i < popped.size(); i++) begin
            chk("basic_data", 64'(popped[i][W-1:0]), 64'(32'hA0 + i));
            chk("basic_stamp", 64'(popped[i][W+31:W]), 64'(7 + i));
        end

        // overflow: 20 beats into a 16-entry buffer with no consumer
        do_reset();
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 1'b1, W'(32'h100 + i), 1'b0);
            tick();
        end
        idle_inputs(1'b0);
        chk("ovf_level", 64'(level), 64'd16);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_drops", 64'(drop_count), 64'd4);

        // full buffer, push and pop together: push accepted, level held
        drive(1'b0, 1'b0, 1'b1, W'(32'h200), 1'b1);
        tick();
        idle_inputs(1'b0);
        chk("fullpp_level", 64'(level), 64'd16);
        chk("fullpp_drops", 64'(drop_count), 64'd4);
        drive(1'b0, 1'b1, 1'b0, '0, 1'b0);
        tick();
        idle_inputs(1'b1);
        for (int i = 0; i < 20; i++) tick();
        chk("drain_n", 64'(popped.size()), 64'd17);
        for (int i = 0; i < 16 && i < popped.size(); i++) begin
            chk("drain_data", 64'(popped[i][W-1:0]), 64'(32'h100 + i));
        end
        if (popped.size() == 17) chk("drain_last", 64'(popped[16][W-1:0]), 64'h200);

        // start and stop together from IDLE: stays IDLE, beats ignored
        drive(1'b1, 1'b1, 1'b0, '0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, W'(32'h300 + i), 1'b0);
            tick();
        end
        idle_inputs(1'b0);
        chk("both_capturing", 64'(capturing), 64'd0);
        chk("both_level", 64'(level), 64'd0);

        // reset mid-capture with 5 records buffered
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b1, W'(32'h400 + i), 1'b0);
            tick();
        end
        idle_inputs(1'b0);
        chk("pre_rst_level", 64'(level), 64'd5);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_valid", 64'(rec_if.rec_valid), 64'd0);
        chk("mid_rst_level", 64'(level), 64'd0);
        chk("mid_rst_capturing", 64'(capturing), 64'd0);
        tick();
        reset_n = 1'b1;
        popped.delete();
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b1, W'(32'h5A5A), 1'b1);
        tick();
        idle_inputs(1'b1);
        for (int i = 0; i < 3; i++) tick();
        chk("restart_n", 64'(popped.size()), 64'd1);
        if (popped.size() > 0) begin
            chk("restart_stamp", 64'(popped[0][W+31:W]), 64'd1);
            chk("restart_data", 64'(popped[0][W-1:0]), 64'h5A5A);
        end

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 4,
                  $urandom_range(0, 99) < 70, W'($urandom), $urandom_range(0, 99) < 45);
            tick();
        end
        idle_inputs(1'b1);
        for (int i = 0; i < 2 * DEPTH; i++) tick();
        chk("final_level", 64'(level), 64'd0);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
